// File: rtl/morph_kernel.sv
// Streaming KxK greyscale erosion/dilation. K-1 cascaded line buffers feed a
// column reduction, then a K-deep shift register of column results feeds the row reduction.
module morph_kernel #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int KSIZE  = 3,
   parameter int ADDR_W = 10
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic              sensor_state,
   input  logic              mode,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_eol
);

   localparam int NBUF   = KSIZE - 1;
   localparam int ROW_W  = $clog2(KSIZE);
   localparam int MEM_AW = $clog2(IMG_W);
   localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] COL_FIRST = ADDR_W'(KSIZE - 1);
   localparam logic [ADDR_W-1:0] COL_ONE   = ADDR_W'(1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(KSIZE - 1);
   localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);

   function automatic logic [DATA_W-1:0] f_op(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic              max_sel);
      if (max_sel) return (a > b) ? a : b;
      return (a < b) ? a : b;
   endfunction

   logic [ADDR_W-1:0]             r_col;
   logic [ROW_W-1:0]              r_row;
   logic                          r_ss_d;
   logic                          r_mode_q;
   logic                          r_v1, r_q1, r_e1;
   logic                          r_v2, r_q2, r_e2;
   logic [ADDR_W-1:0]             r_addr1;
   logic [DATA_W-1:0]             r_in_d1;
   logic [KSIZE-1:0][DATA_W-1:0]  r_csr;
   logic [NBUF-1:0][DATA_W-1:0]   w_rd;
   logic [DATA_W-1:0]             w_col_red;
   logic [DATA_W-1:0]             w_row_red;
   logic                          w_beat;
   logic                          w_qual;
   logic                          w_eol;

   assign w_beat = sensor_state & in_valid;
   assign w_qual = (r_row == ROW_LAST) && (r_col >= COL_FIRST);
   assign w_eol  = (r_col == COL_LAST);

   // Position counters; row saturates once a full window height has been seen.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_col    <= '0;
         r_row    <= '0;
         r_ss_d   <= 1'b0;
         r_mode_q <= 1'b0;
      end else begin
         r_ss_d <= sensor_state;
         if (sensor_state && !r_ss_d) r_mode_q <= mode;
         if (!sensor_state) begin
            r_col <= '0;
            r_row <= '0;
         end else if (in_valid) begin
            if (r_col == COL_LAST) begin
               r_col <= '0;
               if (r_row != ROW_LAST) r_row <= r_row + ROW_ONE;
            end else begin
               r_col <= r_col + COL_ONE;
            end
         end
      end
   end

   // Control pipeline runs every cycle; dropping the frame kills everything in flight.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_v1      <= 1'b0;
         r_q1      <= 1'b0;
         r_e1      <= 1'b0;
         r_v2      <= 1'b0;
         r_q2      <= 1'b0;
         r_e2      <= 1'b0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
      end else if (!sensor_state) begin
         r_v1      <= 1'b0;
         r_q1      <= 1'b0;
         r_e1      <= 1'b0;
         r_v2      <= 1'b0;
         r_q2      <= 1'b0;
         r_e2      <= 1'b0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
      end else begin
         r_v1      <= w_beat;
         r_q1      <= w_beat & w_qual;
         r_e1      <= w_beat & w_eol;
         r_v2      <= r_v1;
         r_q2      <= r_q1;
         r_e2      <= r_e1;
         out_valid <= r_q2;
         out_eol   <= r_q2 & r_e2;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_in_d1  <= '0;
         r_addr1  <= '0;
         r_csr    <= '0;
         out_data <= '0;
      end else begin
         if (w_beat) begin
            r_in_d1 <= in_data;
            r_addr1 <= r_col;
         end
         if (r_v1) r_csr <= {r_csr[KSIZE-2:0], w_col_red};
         if (r_v2) out_data <= w_row_red;
      end
   end

   // Writes lag the read by one cycle so each buffer can take its neighbour's old data.
   genvar gi;
   generate
      for (gi = 0; gi < NBUF; gi++) begin : g_lb
         logic [DATA_W-1:0] r_mem [0:IMG_W-1];
         logic [DATA_W-1:0] r_rd;
         logic [DATA_W-1:0] w_wr;
         if (gi == 0) begin : g_head
            assign w_wr = r_in_d1;
         end else begin : g_tail
            assign w_wr = w_rd[gi-1];
         end
         always_ff @(posedge s_axi_aclk) begin
            if (r_v1) r_mem[r_addr1[MEM_AW-1:0]] <= w_wr;
            if (w_beat) r_rd <= r_mem[r_col[MEM_AW-1:0]];
         end
         assign w_rd[gi] = r_rd;
      end
   endgenerate

   always_comb begin
      w_col_red = r_in_d1;
      for (int i = 0; i < NBUF; i++) w_col_red = f_op(w_col_red, w_rd[i], r_mode_q);
   end

   always_comb begin
      w_row_red = r_csr[0];
      for (int i = 1; i < KSIZE; i++) w_row_red = f_op(w_row_red, r_csr[i], r_mode_q);
   end

endmodule

// File: tb/tb_morph_kernel.sv
// Scoreboard bench: a 3x3 and a 5x5 instance share one stimulus stream; a window
// model predicts each output, and monitors compare value, eol and 3-cycle latency.
module tb_morph_kernel;

   typedef struct {
      logic [7:0] data;
      logic       eol;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic [1:0] rstn;
   logic       sensor_state, mode, in_valid;
   logic [7:0] in_data;
   logic       ov3, oe3, ov5, oe5;
   logic [7:0] od3, od5;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t q3[$];
   exp_t q5[$];
   logic [7:0] pix [2][16][8];
   int   m_row [2];
   int   m_col [2];
   logic m_prev [2];
   logic m_mode [2];
   logic mode_r;
   int   n_out [2];
   int   n_eol [2];
   int   n_zero3, n_ff3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   morph_kernel #(.DATA_W(8), .IMG_W(8), .KSIZE(3), .ADDR_W(3)) dut3 (
      .s_axi_aclk(clk), .s_axi_aresetn(rstn[0]), .sensor_state(sensor_state),
      .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov3), .out_data(od3), .out_eol(oe3));

   morph_kernel #(.DATA_W(8), .IMG_W(8), .KSIZE(5), .ADDR_W(3)) dut5 (
      .s_axi_aclk(clk), .s_axi_aresetn(rstn[1]), .sensor_state(sensor_state),
      .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov5), .out_data(od5), .out_eol(oe5));

   function automatic int kof(input int k);
      return (k == 0) ? 3 : 5;
   endfunction

   function automatic logic [7:0] pixf(input int kind, input int r, input int c);
      case (kind)
         0: return 8'h50;
         1: return (r == 3 && c == 4) ? 8'h00 : 8'hFF;
         2: return (r == 3 && c == 4) ? 8'hFF : 8'h00;
         3: return 8'((r * 37 + c * 11 + 5) & 255);
         default: return 8'(c * 8);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      for (int k = 0; k < 2; k++) begin
         n_out[k] = 0;
         n_eol[k] = 0;
      end
      n_zero3 = 0;
      n_ff3 = 0;
   endtask

   // Reference: keep every accepted pixel and reduce the full KxK window directly.
   task automatic model_step(input int k, input logic ss, input logic v, input logic [7:0] d);
      int kk;
      exp_t e;
      logic [7:0] acc, p;
      if (!rstn[k]) return;
      kk = kof(k);
      if (ss && !m_prev[k]) m_mode[k] = mode_r;
      if (!ss && m_prev[k]) begin
         if (k == 0) while (q3.size() > 0 && q3[$].cyc >= cyc - 2) void'(q3.pop_back());
         else        while (q5.size() > 0 && q5[$].cyc >= cyc - 2) void'(q5.pop_back());
      end
      if (!ss) begin
         m_row[k] = 0;
         m_col[k] = 0;
      end else if (v) begin
         pix[k][m_row[k]][m_col[k]] = d;
         if (m_row[k] >= kk - 1 && m_col[k] >= kk - 1) begin
            acc = d;
            for (int dr = 0; dr < kk; dr++)
               for (int dc = 0; dc < kk; dc++) begin
                  p = pix[k][m_row[k] - dr][m_col[k] - dc];
                  if (m_mode[k]) acc = (p > acc) ? p : acc;
                  else           acc = (p < acc) ? p : acc;
               end
            e.data = acc;
            e.eol  = (m_col[k] == 7);
            e.cyc  = cyc;
            if (k == 0) q3.push_back(e); else q5.push_back(e);
         end
         if (m_col[k] == 7) begin
            m_col[k] = 0;
            if (m_row[k] < 15) m_row[k]++;
         end else begin
            m_col[k]++;
         end
      end
      m_prev[k] = ss;
   endtask

   task automatic drive(input logic ss, input logic v, input logic [7:0] d);
      @(posedge clk);
      #1;
      sensor_state = ss;
      in_valid     = v;
      in_data      = d;
      mode         = mode_r;
      for (int k = 0; k < 2; k++) model_step(k, ss, v, d);
   endtask

   task automatic mon_one(input int k, input logic ov, input logic [7:0] od, input logic oe);
      exp_t e;
      int   qs;
      if (!rstn[k] || !ov) return;
      qs = (k == 0) ? q3.size() : q5.size();
      if (qs == 0) begin
         chk($sformatf("k%0d_spurious_valid", kof(k)), {31'd0, ov}, 32'd0);
         return;
      end
      if (k == 0) e = q3.pop_front(); else e = q5.pop_front();
      chk($sformatf("k%0d_data", kof(k)), {24'd0, od}, {24'd0, e.data});
      chk($sformatf("k%0d_eol", kof(k)), {31'd0, oe}, {31'd0, e.eol});
      chk($sformatf("k%0d_latency", kof(k)), 32'(cyc - e.cyc), 32'd3);
      n_out[k]++;
      if (oe) n_eol[k]++;
      if (k == 0 && od == 8'h00) n_zero3++;
      if (k == 0 && od == 8'hFF) n_ff3++;
   endtask

   always @(negedge clk) begin
      mon_one(0, ov3, od3, oe3);
      mon_one(1, ov5, od5, oe5);
   end

   task automatic run_frame(input int kind, input int rows, input int gap, input logic md,
                            input int toggle_row, input int abort_r, input int abort_c);
      mode_r = md;
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < 8; c++) begin
            if (r == toggle_row && c == 0) mode_r = ~mode_r;
            if (r == abort_r && c == abort_c) begin
               drive(1'b0, 1'b1, pixf(kind, r, c));
               return;
            end
            drive(1'b1, 1'b1, pixf(kind, r, c));
            repeat (gap) drive(1'b1, 1'b0, 8'($urandom));
         end
      repeat (5) drive(1'b1, 1'b0, 8'($urandom));
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rstn = 2'b00;
      sensor_state = 1'b0;
      mode = 1'b0;
      mode_r = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      for (int k = 0; k < 2; k++) begin
         m_row[k] = 0;
         m_col[k] = 0;
         m_prev[k] = 1'b0;
         m_mode[k] = 1'b0;
      end
      clr();
      #22;
      chk("k3_rst_valid", {31'd0, ov3}, 32'd0);
      chk("k3_rst_data", {24'd0, od3}, 32'd0);
      chk("k3_rst_eol", {31'd0, oe3}, 32'd0);
      chk("k5_rst_valid", {31'd0, ov5}, 32'd0);
      chk("k5_rst_data", {24'd0, od5}, 32'd0);
      chk("k5_rst_eol", {31'd0, oe5}, 32'd0);
      @(negedge clk);
      rstn = 2'b11;

      // Flat frame, erosion
      clr();
      run_frame(0, 6, 0, 1'b0, -1, -1, -1);
      chk("flat_k3_count", 32'(n_out[0]), 32'd24);
      chk("flat_k3_eols", 32'(n_eol[0]), 32'd4);
      chk("flat_k5_count", 32'(n_out[1]), 32'd8);
      chk("flat_k5_eols", 32'(n_eol[1]), 32'd2);
      chk("flat_q_drained", 32'(q3.size() + q5.size()), 32'd0);

      // Single dark pixel, erosion
      clr();
      run_frame(1, 8, 0, 1'b0, -1, -1, -1);
      chk("erode_k3_count", 32'(n_out[0]), 32'd36);
      chk("erode_k3_zeros", 32'(n_zero3), 32'd9);
      chk("erode_k5_count", 32'(n_out[1]), 32'd16);

      // Single bright pixel, dilation, mode flipped mid-frame
      clr();
      run_frame(2, 8, 0, 1'b1, 4, -1, -1);
      chk("dilate_k3_count", 32'(n_out[0]), 32'd36);
      chk("dilate_k3_ffs", 32'(n_ff3), 32'd9);

      // Gapped input 1,0,0,...
      clr();
      run_frame(0, 6, 2, 1'b0, -1, -1, -1);
      chk("gap_k3_count", 32'(n_out[0]), 32'd24);
      chk("gap_k3_eols", 32'(n_eol[0]), 32'd4);

      // Frame abort at line 3 col 5, then a fresh frame
      clr();
      run_frame(3, 6, 0, 1'b0, -1, 3, 5);
      @(posedge clk);
      #1;
      chk("abort_k3_valid_low", {31'd0, ov3}, 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      chk("abort_k3_count", 32'(n_out[0]), 32'd7);
      clr();
      run_frame(3, 6, 0, 1'b0, -1, -1, -1);
      chk("restart_k3_count", 32'(n_out[0]), 32'd24);
      chk("restart_k5_count", 32'(n_out[1]), 32'd8);

      // Asynchronous reset of the 5x5 instance mid-line on a ramp
      clr();
      mode_r = 1'b0;
      for (int i = 0; i < 47; i++) drive(1'b1, 1'b1, pixf(4, i / 8, i % 8));
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      #2;
      chk("k5_pre_rst_valid", {31'd0, ov5}, 32'd1);
      chk("k5_pre_rst_data", {24'd0, od5}, 32'd8);
      rstn[1] = 1'b0;
      q5.delete();
      m_row[1] = 0;
      m_col[1] = 0;
      m_prev[1] = 1'b0;
      #1;
      chk("k5_async_valid", {31'd0, ov5}, 32'd0);
      chk("k5_async_data", {24'd0, od5}, 32'd0);
      chk("k5_async_eol", {31'd0, oe5}, 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      #2;
      rstn[1] = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      clr();
      run_frame(4, 6, 0, 1'b0, -1, -1, -1);
      chk("ramp_k5_count", 32'(n_out[1]), 32'd8);
      chk("ramp_k5_eols", 32'(n_eol[1]), 32'd2);
      chk("ramp_k3_count", 32'(n_out[0]), 32'd24);
      chk("final_q_drained", 32'(q3.size() + q5.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
